// File: rtl/rr_bus_mux.sv
// ---------------------------------------------------------------------------
// rr_bus_mux
//   N-channel, WIDTH-bit bus multiplexer for several producers sharing one
//   datapath bus. Each cycle one requesting channel is granted, either by
//   round-robin (RR=1) or by fixed lowest-index priority (RR=0). The grant is
//   held for a whole packet, and the chosen beat goes into a single output
//   register with valid/ready handshaking.
//
//   Ports
//     Clk        rising-edge clock
//     Reset      synchronous, active-low reset
//     in_data    N*WIDTH  channel i at [i*WIDTH +: WIDTH]
//     in_valid   N        per-channel beat valid
//     in_last    N        per-channel end-of-packet, qualified by in_valid
//     in_ready   N        per-channel accept (combinational)
//     out_data   WIDTH    registered selected beat
//     out_valid  1        output register holds a beat
//     out_last   1        registered end-of-packet flag
//     out_ready  1        downstream accept
//     grant      N        one-hot selected channel, zero when none is selected
//     locked     1        a multi-beat packet is in progress
// ---------------------------------------------------------------------------

// Per-channel grant/accept cell. The selection is made centrally and each
// lane only decodes whether it is the selected one.
module rr_bus_mux_lane (
   input  logic sel_hit,   // selected index equals this lane's index
   input  logic sel_any,   // a channel is selected this cycle (and not in reset)
   input  logic load,      // output register can take a beat this cycle
   output logic grant,
   output logic ready
);
   assign grant = sel_hit && sel_any;
   assign ready = grant && load;
endmodule

module rr_bus_mux #(
   parameter int WIDTH = 16,
   parameter int N     = 4,
   parameter bit RR    = 1'b1
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   input  logic [N-1:0]       in_last,
   output logic [N-1:0]       in_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   output logic               out_last,
   input  logic               out_ready,
   output logic [N-1:0]       grant,
   output logic               locked
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;
   // Pointer resets to the last channel so channel 0 is searched first.
   localparam logic [PW-1:0] PTR_RST = PW'(N - 1);

   logic [N-1:0][WIDTH-1:0] ch_data;

   logic [PW-1:0]    ptr_q, ptr_d;
   logic [PW-1:0]    owner_q, owner_d;
   logic             locked_q, locked_d;
   logic             out_valid_q, out_valid_d;
   logic             out_last_q, out_last_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;

   logic [PW-1:0]    arb_idx;
   logic             arb_hit;
   logic [PW-1:0]    sel_idx;
   logic             sel_any;
   logic             load;
   logic             xfer;

   assign ch_data = in_data;

   // ------------------------------------------------------------------
   // Arbitration among valid channels; only consulted while unlocked.
   // ------------------------------------------------------------------
   always_comb begin
      logic [PW-1:0] cand;
      arb_idx = '0;
      arb_hit = 1'b0;
      cand    = '0;
      if (RR) begin
         // Rotating search starting just above the last packet's owner.
         for (int k = 1; k <= N; k++) begin
            cand = PW'((int'(ptr_q) + k) % N);
            if (!arb_hit && in_valid[cand]) begin
               arb_hit = 1'b1;
               arb_idx = cand;
            end
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            cand = PW'(i);
            if (!arb_hit && in_valid[cand]) begin
               arb_hit = 1'b1;
               arb_idx = cand;
            end
         end
      end
   end

   // While locked the owner keeps the grant even with no valid beat, which
   // yields a bubble rather than letting another channel interleave.
   assign sel_idx = locked_q ? owner_q : arb_idx;
   assign sel_any = Reset && (locked_q || arb_hit);
   assign load    = !out_valid_q || out_ready;
   assign xfer    = sel_any && in_valid[sel_idx] && load;

   for (genvar i = 0; i < N; i++) begin : g_lane
      rr_bus_mux_lane u_lane (
         .sel_hit (sel_idx == PW'(i)),
         .sel_any (sel_any),
         .load    (load),
         .grant   (grant[i]),
         .ready   (in_ready[i])
      );
   end

   // ------------------------------------------------------------------
   // Next-state: output register, packet lock and round-robin pointer.
   // ------------------------------------------------------------------
   always_comb begin
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      locked_d    = locked_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      if (xfer) begin
         out_data_d  = ch_data[sel_idx];
         out_last_d  = in_last[sel_idx];
         out_valid_d = 1'b1;
         if (in_last[sel_idx]) begin
            locked_d = 1'b0;
            // Pointer only moves at packet end so a packet's owner is
            // searched last for the following packet.
            if (RR) begin
               ptr_d = sel_idx;
            end
         end else begin
            locked_d = 1'b1;
            owner_d  = sel_idx;
         end
      end else if (out_valid_q && out_ready) begin
         // Popped with nothing to replace it; data/last keep their value.
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         ptr_q       <= PTR_RST;
         owner_q     <= '0;
         locked_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else begin
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         locked_q    <= locked_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign locked    = locked_q;

   // Structural invariants of the grant/accept decode and the stall hold.
   a_grant_onehot: assert property (@(posedge Clk) $onehot0(grant));
   a_ready_in_grant: assert property (@(posedge Clk) (in_ready & ~grant) == '0);
   a_stall_hold: assert property (@(posedge Clk) disable iff (!Reset)
      (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_last)));
endmodule

// File: tb/tb_rr_bus_mux.sv
module tb_rr_bus_mux;
   localparam int W = 16;
   localparam int N = 4;

   typedef struct {
      logic [N-1:0] v;
      logic [N-1:0] last;
      logic         ordy;
      logic [N-1:0] exp_grant;
      logic [N-1:0] exp_rdy;
      logic         exp_ov;
      logic [W-1:0] exp_od;
      logic         exp_ol;
      logic         exp_lock;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   // round-robin instance
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid, in_last, in_ready, grant;
   logic [W-1:0]   out_data;
   logic           out_valid, out_last, out_ready, locked;

   // fixed-priority instance
   logic [N*W-1:0] fp_in_data;
   logic [N-1:0]   fp_in_valid, fp_in_last, fp_in_ready, fp_grant;
   logic [W-1:0]   fp_out_data;
   logic           fp_out_valid, fp_out_last, fp_out_ready, fp_locked;

   rr_bus_mux #(.WIDTH(W), .N(N), .RR(1'b1)) dut (
      .Clk(clk), .Reset(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
      .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
      .grant(grant), .locked(locked));

   rr_bus_mux #(.WIDTH(W), .N(N), .RR(1'b0)) dut_fp (
      .Clk(clk), .Reset(rst_n), .in_data(fp_in_data), .in_valid(fp_in_valid),
      .in_last(fp_in_last), .in_ready(fp_in_ready), .out_data(fp_out_data),
      .out_valid(fp_out_valid), .out_last(fp_out_last), .out_ready(fp_out_ready),
      .grant(fp_grant), .locked(fp_locked));

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   logic [W-1:0] td [N];
   task automatic drive_data();
      for (int i = 0; i < N; i++) in_data[i*W +: W] = td[i];
   endtask

   // Scoreboard: every accepted beat must eventually be popped exactly once.
   int  pushes = 0, pops = 0;
   bit  sb_en = 1'b0;
   always @(posedge clk) begin
      if (sb_en) begin
         pushes <= pushes + $countones(in_valid & in_ready);
         if (out_valid && out_ready) pops <= pops + 1;
      end
   end

   // Reference model state (round-robin instance).
   int           m_ptr, m_owner;
   bit           m_locked, m_ov, m_ol;
   logic [W-1:0] m_od;

   // Candidates are listed in priority order, the first valid one wins.
   function automatic int model_sel(input logic [N-1:0] v);
      int order[$];
      if (m_locked) return m_owner;
      for (int k = 1; k <= N; k++) order.push_back((m_ptr + k) % N);
      foreach (order[j]) if (v[order[j]]) return order[j];
      return -1;
   endfunction

   vec_t tbl [12];
   bit   pend [N];

   initial begin
      tbl[0]  = '{4'b1010, 4'b1111, 1'b1, 4'b0010, 4'b0010, 1'b1, 16'hB001, 1'b1, 1'b0};
      tbl[1]  = '{4'b1010, 4'b1111, 1'b1, 4'b0010, 4'b0010, 1'b1, 16'hB001, 1'b1, 1'b0};
      tbl[2]  = '{4'b1010, 4'b1111, 1'b0, 4'b0010, 4'b0000, 1'b1, 16'hB001, 1'b1, 1'b0};
      tbl[3]  = '{4'b1000, 4'b1111, 1'b1, 4'b1000, 4'b1000, 1'b1, 16'hB003, 1'b1, 1'b0};
      tbl[4]  = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0, 16'hB003, 1'b1, 1'b0};
      tbl[5]  = '{4'b1001, 4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1, 16'hB000, 1'b1, 1'b0};
      tbl[6]  = '{4'b1110, 4'b1111, 1'b0, 4'b0010, 4'b0000, 1'b1, 16'hB000, 1'b1, 1'b0};
      tbl[7]  = '{4'b1100, 4'b1111, 1'b1, 4'b0100, 4'b0100, 1'b1, 16'hB002, 1'b1, 1'b0};
      tbl[8]  = '{4'b1010, 4'b1101, 1'b1, 4'b0010, 4'b0010, 1'b1, 16'hB001, 1'b0, 1'b1};
      tbl[9]  = '{4'b1000, 4'b1101, 1'b1, 4'b0010, 4'b0010, 1'b0, 16'hB001, 1'b0, 1'b1};
      tbl[10] = '{4'b1010, 4'b1111, 1'b1, 4'b0010, 4'b0010, 1'b1, 16'hB001, 1'b1, 1'b0};
      tbl[11] = '{4'b1000, 4'b1111, 1'b1, 4'b1000, 4'b1000, 1'b1, 16'hB003, 1'b1, 1'b0};

      // ---------------- reset with every channel requesting ----------------
      rst_n = 1'b0;
      for (int i = 0; i < N; i++) td[i] = 16'hA000 + 16'(i);
      drive_data();
      in_valid = '1; in_last = '1; out_ready = 1'b1;
      for (int i = 0; i < N; i++) fp_in_data[i*W +: W] = 16'hB000 + 16'(i);
      fp_in_valid = '0; fp_in_last = '1; fp_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_grant", grant, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_locked", locked, 0);

      // ---------------- round-robin fairness ----------------
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rr_first_grant", grant, 4'b0001);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("rr_out_data", out_data, 16'hA000 + 16'(k % 4));
         chk("rr_out_valid", out_valid, 1);
         if (k < 4) chk("rr_grant", grant, 4'b0001 << ((k + 1) % 4));
      end
      in_valid = '0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rr_drain_valid", out_valid, 0);

      // ---------------- packet lock on ch2 with a gap ----------------
      td[2] = 16'hC001; drive_data();
      in_last = 4'b0011; in_valid = 4'b0100;
      #1 chk("lk_grant0", grant, 4'b0100);
      @(posedge clk); #1;
      td[2] = 16'hC002; drive_data(); in_valid = 4'b0111;
      @(negedge clk);
      chk("lk_locked1", locked, 1);
      chk("lk_data1", out_data, 16'hC001);
      chk("lk_grant1", grant, 4'b0100);
      chk("lk_ready1", in_ready, 4'b0100);
      @(posedge clk); #1;
      in_valid = 4'b0011;
      @(negedge clk);
      chk("lk_data2", out_data, 16'hC002);
      chk("lk_gap_grant", grant, 4'b0100);
      chk("lk_gap_locked", locked, 1);
      @(posedge clk); #1;
      td[2] = 16'hC003; drive_data(); in_last = 4'b0111; in_valid = 4'b0111;
      @(negedge clk);
      chk("lk_bubble_valid", out_valid, 0);
      chk("lk_grant3", grant, 4'b0100);
      @(posedge clk); #1;
      in_valid = 4'b0011;
      @(negedge clk);
      chk("lk_data3", out_data, 16'hC003);
      chk("lk_last3", out_last, 1);
      chk("lk_unlocked", locked, 0);
      chk("lk_next_grant", grant, 4'b0001);
      in_valid = '0;
      @(posedge clk); #1;
      @(negedge clk);

      // ---------------- backpressure ----------------
      td[1] = 16'h1234; drive_data(); in_last = '1; in_valid = 4'b0010;
      @(posedge clk); #1;
      td[3] = 16'h5678; drive_data(); in_valid = 4'b1000; out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_data", out_data, 16'h1234);
         chk("bp_valid", out_valid, 1);
         chk("bp_ready", in_ready, 0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", in_ready, 4'b1000);
      chk("bp_release_data", out_data, 16'h1234);
      @(posedge clk); #1 in_valid = '0;
      @(negedge clk);
      chk("bp_new_data", out_data, 16'h5678);
      chk("bp_new_valid", out_valid, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_drained", out_valid, 0);

      // ---------------- reset in the middle of a ch1 packet ----------------
      td[1] = 16'hD001; drive_data(); in_last = '0; in_valid = 4'b0010;
      @(posedge clk); #1;
      td[1] = 16'hD002; drive_data(); rst_n = 1'b0;
      @(negedge clk);
      chk("mr_locked_before", locked, 1);
      chk("mr_grant_in_rst", grant, 0);
      chk("mr_ready_in_rst", in_ready, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mr_locked", locked, 0);
      chk("mr_valid", out_valid, 0);
      chk("mr_data", out_data, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) td[i] = 16'hA000 + 16'(i);
      drive_data(); in_last = '1; in_valid = '1;
      @(negedge clk);
      chk("mr_restart_grant", grant, 4'b0001);
      @(posedge clk); #1 in_valid = '0;
      @(negedge clk);
      chk("mr_restart_data", out_data, 16'hA000);
      @(posedge clk); #1;

      // ---------------- fixed-priority table ----------------
      foreach (tbl[r]) begin
         fp_in_valid = tbl[r].v; fp_in_last = tbl[r].last; fp_out_ready = tbl[r].ordy;
         @(negedge clk);
         chk($sformatf("fp%0d_grant", r), fp_grant, tbl[r].exp_grant);
         chk($sformatf("fp%0d_ready", r), fp_in_ready, tbl[r].exp_rdy);
         @(posedge clk); #1;
         chk($sformatf("fp%0d_ov", r), fp_out_valid, tbl[r].exp_ov);
         chk($sformatf("fp%0d_od", r), fp_out_data, tbl[r].exp_od);
         chk($sformatf("fp%0d_ol", r), fp_out_last, tbl[r].exp_ol);
         chk($sformatf("fp%0d_lock", r), fp_locked, tbl[r].exp_lock);
      end
      fp_in_valid = '0;

      // ---------------- randomized run against the model ----------------
      rst_n = 1'b0; in_valid = '0; out_ready = 1'b1;
      @(posedge clk); #1 rst_n = 1'b1;
      m_ptr = N - 1; m_owner = 0; m_locked = 0; m_ov = 0; m_ol = 0; m_od = '0;
      foreach (pend[i]) pend[i] = 0;
      sb_en = 1'b1;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         int           sel;
         bit           ld, xf;
         logic [N-1:0] eg;
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && ($urandom % 2 == 0)) begin
               pend[i] = 1;
               td[i] = 16'($urandom);
               in_last[i] = ($urandom % 3 == 0);
            end
            in_valid[i] = pend[i];
         end
         drive_data();
         out_ready = ($urandom % 4 != 0);
         sel = model_sel(in_valid);
         ld  = !m_ov || out_ready;
         eg  = (sel >= 0) ? (4'b0001 << sel) : 4'b0000;
         xf  = (sel >= 0) && in_valid[sel] && ld;
         @(negedge clk);
         chk("rnd_grant", grant, eg);
         chk("rnd_ready", in_ready, ld ? eg : 4'b0000);
         chk("rnd_ov", out_valid, m_ov);
         chk("rnd_od", out_data, m_od);
         chk("rnd_ol", out_last, m_ol);
         chk("rnd_lock", locked, m_locked);
         @(posedge clk); #1;
         if (xf) begin
            m_od = td[sel]; m_ol = in_last[sel]; m_ov = 1;
            if (in_last[sel]) begin m_locked = 0; m_ptr = sel; end
            else begin m_locked = 1; m_owner = sel; end
            pend[sel] = 0;
         end else if (m_ov && out_ready) begin
            m_ov = 0;
         end
      end
      sb_en = 1'b0; in_valid = '0;
      @(negedge clk);
      chk("sb_balance", pushes, pops + int'(out_valid));
      chk("sb_nonempty", (pushes > 100), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rr_bus_mux.md
# rr_bus_mux

Parametrised N-channel, WIDTH-bit bus multiplexer with arbitration, packet locking and a registered valid/ready output stage. It supersedes the fixed 2/3/4-way combinational select muxes wherever several producers compete for one shared datapath bus. Typical uses are MDR/ALU/PC sources feeding a common bus, or multiple request streams into one memory port. It selects one requesting channel per cycle by round-robin or fixed priority, holds the grant for a whole packet, and registers the chosen beat.

## Interface
- WIDTH, 16, data bits per channel
- N, 4, number of input channels (2..16)
- RR, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (lowest index wins)

- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-low reset (sampled on Clk rising edge while 0)
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  N  per-channel beat valid
- in_last  in  N  per-channel end-of-packet flag, qualified by in_valid
- in_ready  out  N  per-channel accept; beat i transfers when in_valid[i] && in_ready[i]
- out_data  out  WIDTH  registered selected beat
- out_valid  out  1  out_data/out_last hold a beat
- out_last  out  1  registered end-of-packet flag
- out_ready  in  1  downstream accept
- grant  out  N  one-hot selected channel this cycle; all-zero when none selected
- locked  out  1  a packet is in progress (grant held)

## Operation
- Output stage: single register. load = !out_valid || out_ready. A beat transfers from channel sel when grant[sel] && in_valid[sel] && load.
- in_ready[i] = grant[i] && load. This is combinational, and no channel other than the granted one ever sees in_ready high.
- Arbitration when unlocked:
  - RR=1: search from (ptr+1) mod N upward with wrap; the first channel with in_valid high wins.
  - RR=0: the lowest-indexed valid channel wins; ptr is ignored.
- If no channel is valid, grant = 0.
- Locking: accepting a beat with in_last=0 sets locked and stores the owner. While locked, grant = owner one-hot regardless of in_valid. If the owner has no valid beat, a bubble results, and other channels are not served.
- Accepting a beat with in_last=1 clears locked in the same edge. In RR mode, ptr <= index of that channel.
- A single-beat packet (in_last=1 on the first beat) never asserts locked.
- Output register update on a transfer: out_data <= selected data, out_last <= selected last, out_valid <= 1.
- If out_ready && out_valid and no transfer occurs: out_valid <= 0. out_data and out_last hold their last value.
- Stall: while out_valid && !out_ready, out_data and out_last are stable and all in_ready are 0.
- in_valid dropping on a non-granted channel has no effect. Upstream must not drop in_valid or change data while waiting for in_ready; this is a protocol assertion for verification, not checked in RTL.

## Timing
- Reset (Reset=0 at an edge): out_valid=0, out_data=0, out_last=0, locked=0, owner=0, ptr=N-1 (so channel 0 has first RR priority).
- During reset, in_ready=0 and grant=0. Reset mid-packet discards the lock and any held output beat.
- Latency: 1 cycle, input accept edge -> out_valid high on the next cycle.
- Throughput: 1 beat/cycle with out_ready held high; no bubble between packets from different channels.
- Simultaneous pop and push (out_valid && out_ready && transfer): the register is overwritten, out_valid stays 1, and no beat is lost.
- Arbitration decision, grant and in_ready are combinational from in_valid, locked, owner, ptr and out_ready. There is no combinational path from in_data to any output.
- ptr wraps N-1 -> 0.

## Test plan
- Reset: hold Reset=0 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, grant=0, in_ready=0. On the first cycle after release, grant=0001 (channel 0).
- Round-robin fairness (N=4, RR=1, out_ready=1): all channels valid with single-beat packets (in_last=1), data = 16'hA000+i -> out_data sequence A000, A001, A002, A003, A000, one per cycle, each 1 cycle after its accept.
- Packet lock: ch2 sends 3 beats (last on beat 3) while ch0 and ch1 are valid. Insert a 1-cycle in_valid gap on ch2 -> grant stays 0100 throughout including the gap, locked=1 until the beat-3 edge, then the next grant is ch3 if valid, otherwise ch0.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1, out_data=16'h1234 -> out_data stays 1234 and all in_ready are 0. When out_ready rises, the new beat appears the next cycle and nothing is dropped or duplicated (scoreboard count matches).
- Fixed priority (RR=0): ch1 and ch3 both continuously valid with single-beat packets -> ch3 is never granted while ch1 is valid, and is served when ch1 deasserts.
- Reset mid-packet: assert Reset=0 after beat 1 of a 3-beat ch1 packet -> locked=0 and out_valid=0 the next cycle. After release, arbitration restarts from channel 0.
